clkgen_bank: RTL and testbench

- Multi-channel, runtime-programmable clock/tick generator clocked by the board clock.
- Per channel: period and high-time registers, a shadow/active register pair for glitch-free reprogramming, an enable, and a one-cycle tick strobe per period.
- Feeds display scan, debounce, timers and other logic that needs slow clocks or periodic strobes from one module.

---
 rtl/clkgen_pkg.sv | 32 +++
 rtl/clkgen_channel.sv | 123 ++++++++++++
 rtl/clkgen_bank.sv | 61 ++++++
 tb/tb_clkgen_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared constants and the write-time clamp decision for the
// clkgen_bank tick/clock generator.
package clkgen_pkg;

  // Default width of period / high-time values.
  localparam int CLKGEN_DIV_W = 32;

  // Widest period / high-time value the clamp helper accepts.
  localparam int CLKGEN_MAX_W = 64;

  // Shortest legal period in clkin cycles; anything shorter is raised to this.
  localparam int PERIOD_MIN = 2;

  // Clamp decision for a programmed (period, high) pair, zero-extended to
  // CLKGEN_MAX_W bits. Returns {use_min_period, use_period_as_high}:
  //   bit 1: the period is below PERIOD_MIN and must be stored as PERIOD_MIN
  //   bit 0: the high time exceeds the (clamped) period and must be stored
  //          as the clamped period, which keeps the output high.
  // Returning flags rather than values lets each channel apply the result
  // in its own DIV_W width.
  function automatic logic [1:0] clamp_decide(
    input logic [CLKGEN_MAX_W-1:0] period,
    input logic [CLKGEN_MAX_W-1:0] high
  );
    logic                    use_min;
    logic [CLKGEN_MAX_W-1:0] period_c;
    use_min  = (period < CLKGEN_MAX_W'(PERIOD_MIN));
    period_c = use_min ? CLKGEN_MAX_W'(PERIOD_MIN) : period;
    return {use_min, (high > period_c)};
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// clkgen_channel: one divider channel of clkgen_bank. A free-running counter
// over [0, period_act-1], a shadow/active register pair that only swaps at
// the wrap (or on sync), a registered clkout whose high phase is the last
// high_act cycles of each period, and a one-cycle tick at count 0.
// Optional feature: `define CLKGEN_SYNC_EN adds the sync input.
import clkgen_pkg::*;

module clkgen_channel #(
  parameter int DIV_W      = CLKGEN_DIV_W,
  parameter int DEF_PERIOD = 50000
) (
  input  logic             clkin,
  input  logic             rst,
`ifdef CLKGEN_SYNC_EN
  input  logic             sync,
`endif
  input  logic             clken,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_period,
  input  logic [DIV_W-1:0] wr_high,
  output logic             clkout,
  output logic             tick,
  output logic             pend
);

  localparam logic [DIV_W-1:0] DEF_P = DIV_W'(DEF_PERIOD);
  localparam logic [DIV_W-1:0] DEF_H = DIV_W'(DEF_PERIOD / 2);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] P_MIN = DIV_W'(PERIOD_MIN);

  logic [DIV_W-1:0] count, count_n;
  logic [DIV_W-1:0] period_act, period_n;
  logic [DIV_W-1:0] high_act, high_n;
  logic [DIV_W-1:0] period_sh, psh_n;
  logic [DIV_W-1:0] high_sh, hsh_n;
  logic             pend_n, clkout_n, tick_n;
  logic             sync_i, load, wrap;
  logic [1:0]       clamp_sel;
  logic [DIV_W-1:0] period_c, high_c;

`ifdef CLKGEN_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  // Clamp the incoming write so the shadow always holds a legal setting.
  always_comb begin
    clamp_sel = clamp_decide(CLKGEN_MAX_W'(wr_period), CLKGEN_MAX_W'(wr_high));
    period_c  = clamp_sel[1] ? P_MIN : wr_period;
    high_c    = clamp_sel[0] ? period_c : wr_high;
  end

  // Next-state: sync/wrap/increment, shadow load, clkout from the new count
  // and new settings, then the write (which lands after any load).
  always_comb begin
    count_n  = count;
    period_n = period_act;
    high_n   = high_act;
    psh_n    = period_sh;
    hsh_n    = high_sh;
    pend_n   = pend;
    clkout_n = clkout;
    tick_n   = 1'b0;
    load     = 1'b0;
    wrap     = (count == period_act - ONE);

    if (sync_i) begin
      count_n  = '0;
      load     = pend;
    end else if (clken) begin
      if (wrap) begin
        count_n = '0;
        tick_n  = 1'b1;
        load    = pend;
      end else begin
        count_n = count + ONE;
      end
    end

    if (load) begin
      period_n = period_sh;
      high_n   = high_sh;
      pend_n   = 1'b0;
    end

    if (sync_i) begin
      clkout_n = 1'b0;
    end else if (clken) begin
      clkout_n = (count_n >= period_n - high_n);
    end

    if (wr_en) begin
      psh_n  = period_c;
      hsh_n  = high_c;
      pend_n = 1'b1;
    end
  end

  // State registers with synchronous reset to the default frequency.
  always_ff @(posedge clkin) begin
    if (rst) begin
      count      <= '0;
      period_act <= DEF_P;
      high_act   <= DEF_H;
      period_sh  <= DEF_P;
      high_sh    <= DEF_H;
      pend       <= 1'b0;
      clkout     <= 1'b0;
      tick       <= 1'b0;
    end else begin
      count      <= count_n;
      period_act <= period_n;
      high_act   <= high_n;
      period_sh  <= psh_n;
      high_sh    <= hsh_n;
      pend       <= pend_n;
      clkout     <= clkout_n;
      tick       <= tick_n;
    end
  end

endmodule

// File: rtl/clkgen_bank.sv
// clkgen_bank: NUM_CH independent programmable clock/tick channels.
// Write interface: wr_en is a single-cycle strobe with no back-pressure;
// wr_ch selects the channel and values of wr_ch >= NUM_CH are dropped.
// Optional feature: `define CLKGEN_SYNC_EN adds the sync input, which
// restarts every channel at count 0 and loads any pending shadows.
import clkgen_pkg::*;

module clkgen_bank #(
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = CLKGEN_DIV_W,
  parameter int CLK_FREQ   = 50000000,
  parameter int DEF_FREQ   = 1000,
  parameter int DEF_PERIOD = CLK_FREQ / DEF_FREQ,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              rst,
`ifdef CLKGEN_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NUM_CH-1:0] clken,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_period,
  input  logic [DIV_W-1:0]  wr_high,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] wr_sel;

  // Decode wr_ch into one-hot channel write enables; out-of-range hits none.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_en && (int'(wr_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkgen_channel #(
      .DIV_W      (DIV_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clkin     (clkin),
      .rst       (rst),
`ifdef CLKGEN_SYNC_EN
      .sync      (sync),
`endif
      .clken     (clken[g]),
      .wr_en     (wr_sel[g]),
      .wr_period (wr_period),
      .wr_high   (wr_high),
      .clkout    (clkout[g]),
      .tick      (tick[g]),
      .pend      (pend[g])
    );
  end

endmodule

// File: tb/tb_clkgen_bank.sv
// tb_clkgen_bank: scoreboard bench for clkgen_bank. The driver applies one
// input set per cycle, advances a behavioural model of every channel and
// pushes the expected {pend, tick, clkout} vector; a monitor on the falling
// edge pops and compares. Build with +define+CLKGEN_SYNC_EN to cover sync.
module tb_clkgen_bank;

  localparam int NUM_CH     = 5;
  localparam int DIV_W      = 32;
  localparam int CLK_FREQ   = 1000;
  localparam int DEF_FREQ   = 100;
  localparam int DEF_PERIOD = CLK_FREQ / DEF_FREQ;
  localparam int CH_W       = 3;
  localparam int W          = 3 * NUM_CH;
  localparam logic [NUM_CH-1:0] ALL = '1;

  logic              clkin = 1'b0;
  logic              rst;
  logic              sync;
  logic [NUM_CH-1:0] clken;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_period;
  logic [DIV_W-1:0]  wr_high;
  logic [NUM_CH-1:0] clkout;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within the period, the active and pending
  // settings, and the last registered outputs of each channel.
  longint m_pos[NUM_CH];
  longint m_per[NUM_CH];
  longint m_hi[NUM_CH];
  longint m_nper[NUM_CH];
  longint m_nhi[NUM_CH];
  bit     m_pend[NUM_CH];
  bit     m_clk[NUM_CH];
  bit     m_tick[NUM_CH];

  clkgen_bank #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .CLK_FREQ (CLK_FREQ),
    .DEF_FREQ (DEF_FREQ)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
`ifdef CLKGEN_SYNC_EN
    .sync      (sync),
`endif
    .clken     (clken),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_period (wr_period),
    .wr_high   (wr_high),
    .clkout    (clkout),
    .tick      (tick),
    .pend      (pend)
  );

  // Clock.
  always #5 clkin = ~clkin;

  // Advance the model by one clkin edge.
  task automatic model_step(input bit r, input logic [NUM_CH-1:0] en, input bit we,
                            input int ch, input longint p, input longint h, input bit s);
    for (int i = 0; i < NUM_CH; i++) begin
      bit take;
      take = 1'b0;
      if (r) begin
        m_pos[i] = 0; m_per[i] = DEF_PERIOD; m_hi[i] = DEF_PERIOD / 2;
        m_nper[i] = DEF_PERIOD; m_nhi[i] = DEF_PERIOD / 2;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else begin
        m_tick[i] = 0;
        if (s) begin
          m_pos[i] = 0;
          take = m_pend[i];
        end else if (en[i]) begin
          if (m_pos[i] + 1 == m_per[i]) begin
            m_pos[i] = 0;
            m_tick[i] = 1;
            take = m_pend[i];
          end else begin
            m_pos[i] = m_pos[i] + 1;
          end
        end
        if (take) begin
          m_per[i] = m_nper[i];
          m_hi[i]  = m_nhi[i];
          m_pend[i] = 0;
        end
        // High phase is the last m_hi positions of the period.
        if (s) m_clk[i] = 0;
        else if (en[i]) m_clk[i] = (m_pos[i] + m_hi[i] >= m_per[i]);
        if (we && ch == i) begin
          m_nper[i] = (p < 2) ? 2 : p;
          m_nhi[i]  = (h > m_nper[i]) ? m_nper[i] : h;
          m_pend[i] = 1;
        end
      end
    end
  endtask

  // Driver: apply one cycle of inputs, update model, push expectation.
  task automatic apply(input bit r, input logic [NUM_CH-1:0] en, input bit we,
                       input int ch, input longint p, input longint h, input bit s);
    logic [W-1:0] e;
    rst = r; clken = en; wr_en = we; wr_ch = CH_W'(ch);
    wr_period = DIV_W'(p); wr_high = DIV_W'(h); sync = s;
    model_step(r, en, we, ch, p, h, s);
    for (int i = 0; i < NUM_CH; i++) begin
      e[i]            = m_clk[i];
      e[NUM_CH + i]   = m_tick[i];
      e[2*NUM_CH + i] = m_pend[i];
    end
    exp_q.push_back(e);
    @(posedge clkin);
    #1;
  endtask

  task automatic run(input int n, input logic [NUM_CH-1:0] en);
    for (int k = 0; k < n; k++) apply(1'b0, en, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // Monitor: compare registered outputs away from the active edge.
  always @(negedge clkin) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, g;
      e = exp_q.pop_front();
      g = {pend, tick, clkout};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs vec %0d t=%0t: got clkout=%b tick=%b pend=%b, want clkout=%b tick=%b pend=%b",
                 n_vec, $time, g[NUM_CH-1:0], g[2*NUM_CH-1:NUM_CH], g[W-1:2*NUM_CH],
                 e[NUM_CH-1:0], e[2*NUM_CH-1:NUM_CH], e[W-1:2*NUM_CH]);
      end
    end
  end

  // Stimulus.
  initial begin
    int budget;
    // Reset, then default 10-cycle period on every channel.
    apply(1'b1, ALL, 1'b0, 0, 0, 0, 1'b0);
    apply(1'b1, ALL, 1'b0, 0, 0, 0, 1'b0);
    run(25, ALL);
    // Mid-period reprogram of ch1 to period 4, high 1.
    apply(1'b0, ALL, 1'b1, 1, 4, 1, 1'b0);
    run(30, ALL);
    // Clamped write on ch0: period 1 -> 2, high 7 -> 2.
    apply(1'b0, ALL, 1'b1, 0, 1, 7, 1'b0);
    run(12, ALL);
    // Hold ch2 for 5 cycles.
    run(6, ALL);
    run(5, 5'b11011);
    run(15, ALL);
    // Reset while ch3 has a pending write.
    apply(1'b0, ALL, 1'b1, 3, 6, 3, 1'b0);
    run(2, ALL);
    apply(1'b1, ALL, 1'b0, 0, 0, 0, 1'b0);
    run(12, ALL);
    // Out-of-range channel writes are dropped.
    apply(1'b0, ALL, 1'b1, 5, 3, 1, 1'b0);
    apply(1'b0, ALL, 1'b1, 7, 3, 1, 1'b0);
    run(12, ALL);
    // Repeated writes before a wrap: last one wins; high 0 holds output low.
    apply(1'b0, ALL, 1'b1, 4, 3, 2, 1'b0);
    apply(1'b0, ALL, 1'b1, 4, 5, 0, 1'b0);
    run(20, ALL);
`ifdef CLKGEN_SYNC_EN
    // Two pending writes, then sync loads both and restarts all channels.
    apply(1'b0, ALL, 1'b1, 0, 3, 1, 1'b0);
    apply(1'b0, ALL, 1'b1, 1, 7, 2, 1'b0);
    run(2, ALL);
    apply(1'b0, 5'b00100, 1'b1, 2, 4, 4, 1'b1);
    run(20, ALL);
`endif
    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      bit r, we, s;
      logic [NUM_CH-1:0] en;
      r  = ($urandom_range(0, 150) == 0);
      en = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : ALL;
      we = ($urandom_range(0, 4) == 0);
`ifdef CLKGEN_SYNC_EN
      s  = ($urandom_range(0, 40) == 0);
`else
      s  = 1'b0;
`endif
      apply(r, en, we, int'($urandom_range(0, 7)), longint'($urandom_range(0, 12)),
            longint'($urandom_range(0, 14)), s);
    end
    run(10, ALL);
    // Drain the scoreboard under a bounded wait.
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clkin);
      budget++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
